// File: rtl/axi_chan_pkg.sv
// Shared channel types for the VALID/READY transmitter and receiver ends.
// Latency: none (types only).
// Backpressure: none (types only).
package axi_chan_pkg;

    // Channel side FSM: IDLE holds VALID low, SEND holds a word on the bus
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Width of an occupancy counter that can represent 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Circular buffer of DEPTH words with an extra pointer bit to separate full from empty.
// Latency: a pushed word becomes the head on the edge after the push; rdata is the head, combinational.
// Backpressure: a push while full and a pop while empty are ignored; the caller gates on full/empty.
module chan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with differing MSB means the writer is one lap ahead
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign rdata     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; no reset needed since empty masks stale contents
    always_ff @(posedge ACLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer advance; both wrap naturally through the extra MSB
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_channel.sv
// VALID/READY source: queues upstream words and presents them on a registered VALID/xDATA stage.
// Latency: a load into an idle, empty block is on the bus one cycle later; one word per cycle when READY is held.
// Backpressure: VALID/xDATA freeze while READY is low; tx_ready drops only when the FIFO is full (DEPTH+1 words held).
module tx_channel
    import axi_chan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    output logic             VALID,
    input  logic             READY,
    output logic [WIDTH-1:0] xDATA,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             tx_done,
    output logic             tx_idle
);

    localparam int CW = cnt_w(DEPTH);

    state_t           r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_done;

    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] w_fifo_rdata;
    logic             w_push;
    logic             w_hs;
    logic             w_avail;
    logic             w_load;
    logic             w_pop;
    logic             w_fifo_push;
    logic [WIDTH-1:0] w_next;

    assign w_push  = tx_load && !w_full;
    assign w_hs    = r_valid && READY;
    assign w_avail = !w_empty || w_push;
    // The output stage refills only when it is free: idle, or emptied by this edge's handshake
    assign w_load  = w_avail && ((r_state == IDLE) || w_hs);
    // Head of the FIFO always wins so older words never get overtaken by the bypass
    assign w_next  = w_empty ? tx_data : w_fifo_rdata;
    assign w_pop   = w_load && !w_empty;
    // A word that goes straight to the output register must not also be queued
    assign w_fifo_push = w_push && !(w_load && w_empty);

    assign VALID    = r_valid;
    assign xDATA    = r_data;
    assign tx_done  = r_done;
    assign tx_ready = !w_full;
    assign tx_idle  = w_empty && !r_valid;

    chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push    (w_fifo_push),
        .wdata   (tx_data),
        .pop     (w_pop),
        .rdata   (w_fifo_rdata),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Occupancy sanity: the queue never holds more than DEPTH words
    always_comb begin
        assert (w_count <= CW'(DEPTH));
    end

    // Source FSM with registered VALID/xDATA and a done pulse one cycle after each handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs;
            case (r_state)
                IDLE: begin
                    if (w_avail) begin
                        r_state <= SEND;
                        r_valid <= 1'b1;
                        r_data  <= w_next;
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (w_avail) begin
                            r_data <= w_next;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/tx_channel.md
Name: tx_channel

Overview:
- Transmitter end of the single-channel VALID/READY handshake. It drives VALID and xDATA onto the bus and consumes READY from the receiving channel.
- An upstream module loads words through a simple load/ready interface.
- A DEPTH-entry FIFO plus a registered output stage absorb bus stalls.
- Guarantees the AXI source rules: VALID never waits on READY, and VALID/xDATA stay stable until the handshake completes.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 2, FIFO entries excluding the output register; power of 2, at least 2.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  reset, asynchronous and active-low.
- VALID  out  1  bus valid; driven from a register.
- READY  in  1  bus ready from the receiver.
- xDATA  out  WIDTH  bus data; driven from a register.
- tx_data  in  WIDTH  word from the upstream module.
- tx_load  in  1  upstream request to enqueue tx_data this cycle.
- tx_ready  out  1  block can accept a word this cycle; equals !fifo_full.
- tx_done  out  1  one-cycle pulse, registered, in the cycle after each bus handshake.
- tx_idle  out  1  FIFO empty and VALID=0.

Behaviour:
- Reset (async assert, sync release): VALID=0, xDATA=0, tx_done=0, FIFO pointers and count = 0, state=IDLE, tx_ready=1, tx_idle=1. Reset mid-transfer drops VALID immediately and discards all queued words.
- push = tx_load && tx_ready. A tx_load while full is ignored; no overwrite, no error flag.
- hs = VALID && READY, sampled at the rising edge.
- FSM (enum state_t):
  - IDLE (VALID=0) -> SEND when a word is available, from the FIFO or a bypass push.
  - SEND (VALID=1) -> IDLE on hs with FIFO empty and no push.
  - SEND -> SEND on hs when a next word exists; the output register reloads with no bubble.
  - SEND without hs: hold, with VALID and xDATA frozen.
- Output register load priority:
  - If the FIFO is non-empty, load from the FIFO head.
  - Else, if push, load tx_data directly (bypass; it does not enter the FIFO).
  - A load happens only in IDLE, or in SEND on hs.
- Latency: push into an empty block in IDLE at edge N gives VALID=1 and xDATA=tx_data after edge N. That is one cycle, visible in the cycle following the tx_load cycle.
- Back-to-back throughput: with READY held high, one word per cycle is sustained.
- FIFO:
  - Circular buffer, pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and pointers wrap naturally.
  - count range is 0..DEPTH.
  - Simultaneous push and pop in the same cycle with 0<count<DEPTH leaves count unchanged.
  - Pop occurs only when the output register loads from the FIFO.
- Ordering: strict FIFO order is preserved at all times. Bypass is allowed only when the FIFO is empty.
- Total storage is DEPTH+1 words. tx_ready=0 only when the FIFO is full, regardless of the output register.
- VALID must not combinationally depend on READY or tx_load. READY may toggle arbitrarily while VALID=0 with no effect.
- tx_done=1 for exactly one cycle after each hs edge; back-to-back handshakes give tx_done held high for consecutive cycles.
- tx_idle is combinational from registered state.

Decomposition:
- Package axi_chan_pkg holds typedef enum logic {IDLE, SEND} state_t, shared with the receiver side later.
- Sub-module chan_fifo (WIDTH, DEPTH) holds the circular buffer.
  - Ports: ACLK, ARESETn, push, wdata, pop, rdata (head, combinational), full, empty, count.
- tx_channel contains the FSM, the output register and the bypass mux.

Test Plan:
- Reset and single word: hold ARESETn=0 -> VALID=0, tx_ready=1, tx_idle=1. Release, tx_load 0xA5 with READY=1 -> VALID=1 with xDATA=0xA5 next cycle; hs; tx_done pulses once; tx_idle returns to 1.
- Stall and stability: READY=0, load 0x11, 0x22, 0x33 on consecutive cycles.
  - Expect VALID=1 with xDATA=0x11 held steady; tx_ready=0 after the third load (DEPTH=2).
  - A fourth load of 0x44 is dropped.
  - Raise READY -> 0x11, 0x22, 0x33 appear on consecutive cycles, then VALID=0.
- Streaming: READY=1, tx_load every cycle with 0x00..0x0F -> 16 handshakes in 16 consecutive cycles, tx_done high for 16 cycles, data in order.
- Random READY backpressure with random tx_load over 1000 words:
  - Scoreboard confirms exact order.
  - Assertion: VALID never deasserts and xDATA never changes while VALID && !READY.
- Wrap-around and simultaneous push/pop: toggle READY every other cycle while loading every cycle for 20 words -> pointers wrap repeatedly, no loss or duplication, count never exceeds 2.
- Reset mid-operation: assert ARESETn low asynchronously (between edges) with VALID=1 and a full FIFO.
  - VALID drops immediately.
  - After release, tx_idle=1 and no stale word is ever emitted.
